hamming_secded_serial_decoder: RTL and testbench
================================================

// Module: hamming_secded_serial_decoder
// PURPOSE
//  Parametrised serial Hamming decoder, next generation of the fixed (15,11) serial decoder.
//  Accepts one code bit per handshake, accumulates syndrome on the fly, buffers the frame,
//  corrects single errors, detects double errors (optional extended parity), and presents the
//  decoded data word on a valid/ready output. Keeps saturating error statistics.
//  Sits between the serial line receiver and the word-level consumer.
// PARAMETERS
//  R     4   parity bits; N = 2**R-1 code bits, K = N-R data bits (R=4 -> 15,11)
//  EXT   1   1: extra overall-parity bit after position N (SECDED); 0: plain SEC
//  CNTW  16  width of each error statistics counter
// PORTS
//  clk             in   1     clock, all state on rising edge
//  rst_n           in   1     asynchronous active-low reset
//  in_bit          in   1     serial code bit
//  in_sof          in   1     marks first bit (position 1) of a frame
//  in_valid        in   1     in_bit/in_sof valid
//  in_ready        out  1     decoder can accept a bit
//  out_data        out  K     corrected data word
//  out_syndrome    out  R     raw syndrome of the frame
//  out_corrected   out  1     single error was corrected
//  out_uncorr      out  1     double error detected (EXT=1 only), data uncorrected
//  out_valid       out  1     output word valid; held until accepted
//  out_ready       in   1     consumer accepts word
//  sync_err        out  1     one-cycle pulse: frame aborted by in_sof or missing sof
//  cnt_corr        out  CNTW  saturating count of corrected frames
//  cnt_uncorr      out  CNTW  saturating count of uncorrectable frames
// BEHAVIOUR
//  Reset: all outputs 0, in_ready 1, position counter idle, buffer/syndrome/parity cleared.
//  Bit accepted when in_valid && in_ready. Frame = L = N+EXT bits, position 1..N, then EXT bit.
//  Position p: buffer[p]<=bit; syndrome ^= bit ? p : 0; overall parity ^= bit.
//  Bit with in_sof: always starts a new frame at p=1; if a frame was partly received, it is
//   discarded and sync_err pulses. Bit without in_sof while idle: dropped, sync_err pulses.
//  Decode on final bit (s = syndrome incl. that bit, P = overall parity, EXT=1):
//   s=0,P=0 clean; P=1 single error -> flip position s (s=0: error in ext bit, data intact),
//   out_corrected=1; s!=0,P=0 -> out_uncorr=1, data passed uncorrected.
//   EXT=0: s!=0 -> flip position s, out_corrected=1.
//  out_data[i] = corrected bit at the i-th non-power-of-2 position, ascending (bit0 = pos 3).
//  Latency: final bit accepted at edge T -> out_valid and all out_* registered at edge T;
//   valid from that cycle until out_valid && out_ready; values stable while held.
//  Backpressure: next frame may be received while output held; in_ready drops only when the
//   next bit would be a final bit and out_valid && !out_ready. Accept and new result on the
//   same edge: old word retires, new word loads, out_valid stays 1.
//  Counters increment on result load; saturate at 2**CNTW-1; cleared only by reset.
//  Reset mid-frame or mid-hold: everything returns to reset values immediately.
// STRUCTURE
//  hamming_pkg: is_pow2(p), data_index(p) mapping, L/N/K localparam helpers.
//  Sub-module hamming_correct (combinational): buffer+syndrome+parity -> data, flags.
//  Top: position counter/FSM (IDLE, RX), syndrome/parity accumulators, output register, counters.
// TESTING
//  R=4,EXT=1: all-zero frame (16 zeros) -> out_data=0, syndrome=0, no flags, 1 cycle latency.
//  All-ones frame (16 ones) with pos 5 flipped -> syndrome=5, corrected=1, data=11'h7FF.
//  All-ones frame with pos 3 and 6 flipped -> syndrome=5, uncorr=1, cnt_uncorr=1.
//  Zero frame with ext bit flipped -> syndrome=0, corrected=1, data=0, cnt_corr increments.
//  Hold out_ready=0 across two frames -> in_ready low on 2nd final bit; first word unchanged.
//  in_sof at position 7 -> sync_err pulse, new frame decodes cleanly; reset mid-frame -> idle.

Source files
------------

// File: rtl/hamming_secded_serial_decoder_pkg.sv
// Shared types and helpers for the serial SECDED decoder.
// Code geometry: N = 2**R-1 code positions, K = N-R data bits,
// L = N+EXT bits per frame (the overall-parity bit follows position N).
package hamming_secded_serial_decoder_pkg;

    typedef enum logic {ST_IDLE, ST_RX} state_t;

    function automatic int n_of(int r);
        return (1 << r) - 1;
    endfunction

    function automatic int k_of(int r);
        return n_of(r) - r;
    endfunction

    function automatic int l_of(int r, int ext);
        return n_of(r) + ext;
    endfunction

    // Parity bits sit at power-of-two positions.
    function automatic bit is_pow2(int p);
        return (p > 0) && ((p & (p - 1)) == 0);
    endfunction

    // Data bit index of code position p: count of non-power-of-2 positions below p.
    function automatic int data_index(int p);
        int c;
        c = 0;
        for (int i = 1; i < p; i++)
            if (!is_pow2(i)) c++;
        return c;
    endfunction

endpackage

// File: rtl/hamming_secded_serial_decoder_if.sv
// Bit-serial input stream, word output stream and status of the decoder.
//   in_bit/in_sof/in_valid/in_ready : one code bit per handshake
//   out_data/out_syndrome/out_corrected/out_uncorr/out_valid/out_ready : decoded word
//   sync_err, cnt_corr, cnt_uncorr : framing pulse and saturating statistics
// slave = decoder side, master = producer/consumer side.
interface hamming_secded_serial_decoder_if #(
    parameter int R    = 4,
    parameter int CNTW = 16
);
    localparam int K = hamming_secded_serial_decoder_pkg::k_of(R);

    logic            in_bit;
    logic            in_sof;
    logic            in_valid;
    logic            in_ready;
    logic [K-1:0]    out_data;
    logic [R-1:0]    out_syndrome;
    logic            out_corrected;
    logic            out_uncorr;
    logic            out_valid;
    logic            out_ready;
    logic            sync_err;
    logic [CNTW-1:0] cnt_corr;
    logic [CNTW-1:0] cnt_uncorr;

    modport slave (
        input  in_bit, in_sof, in_valid, out_ready,
        output in_ready, out_data, out_syndrome, out_corrected, out_uncorr,
               out_valid, sync_err, cnt_corr, cnt_uncorr
    );

    modport master (
        output in_bit, in_sof, in_valid, out_ready,
        input  in_ready, out_data, out_syndrome, out_corrected, out_uncorr,
               out_valid, sync_err, cnt_corr, cnt_uncorr
    );
endinterface

// File: rtl/hamming_secded_serial_decoder_correct.sv
// Combinational correction stage.
//   i_data : K received data bits (already extracted from code positions)
//   i_syn  : syndrome of the whole frame
//   i_par  : overall parity of the whole frame (used when EXT=1)
//   o_data : corrected data word
//   o_corr / o_unc : single error corrected / double error detected
module hamming_secded_serial_decoder_correct
    import hamming_secded_serial_decoder_pkg::*;
#(
    parameter int R   = 4,
    parameter int EXT = 1
) (
    input  logic [k_of(R)-1:0] i_data,
    input  logic [R-1:0]       i_syn,
    input  logic               i_par,
    output logic [k_of(R)-1:0] o_data,
    output logic               o_corr,
    output logic               o_unc
);
    localparam int N = n_of(R);

    logic w_flip;

    always_comb begin
        w_flip = 1'b0;
        o_corr = 1'b0;
        o_unc  = 1'b0;
        if (EXT != 0) begin
            // Odd overall parity means one error; syndrome 0 then points at the ext bit.
            if (i_par) begin
                o_corr = 1'b1;
                w_flip = (i_syn != '0);
            end else if (i_syn != '0) begin
                o_unc = 1'b1;
            end
        end else if (i_syn != '0) begin
            o_corr = 1'b1;
            w_flip = 1'b1;
        end
    end

    // Errors at parity positions need no data fix-up; only data positions are flipped.
    always_comb begin
        o_data = i_data;
        for (int p = 1; p <= N; p++)
            if (!is_pow2(p))
                o_data[data_index(p)] = i_data[data_index(p)] ^ (w_flip && (i_syn == R'(p)));
    end
endmodule

// File: rtl/hamming_secded_serial_decoder.sv
// Serial Hamming SEC/SECDED decoder.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of hamming_secded_serial_decoder_if
// Bits are accepted one per handshake; syndrome and overall parity accumulate on
// the fly, data bits are buffered, and the result is registered on the edge that
// accepts the final bit. The output word is held until accepted while the next
// frame keeps streaming in; only the next frame's final bit can be stalled.
module hamming_secded_serial_decoder
    import hamming_secded_serial_decoder_pkg::*;
#(
    parameter int R    = 4,
    parameter int EXT  = 1,
    parameter int CNTW = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    hamming_secded_serial_decoder_if.slave bus
);
    localparam int N  = n_of(R);
    localparam int K  = k_of(R);
    localparam int L  = l_of(R, EXT);
    localparam int PW = $clog2(L + 1);

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_pos, w_pos;
    logic [K-1:0]    r_buf, w_buf;
    logic [R-1:0]    r_syn, w_syn;
    logic            r_par, w_par;
    logic            w_acc, w_take, w_final, w_bad, w_load;
    logic [K-1:0]    w_data;
    logic            w_corr, w_unc;

    logic [K-1:0]    r_data;
    logic [R-1:0]    r_syn_out;
    logic            r_corr, r_unc, r_valid, r_sync_err;
    logic [CNTW-1:0] r_cnt_corr, r_cnt_unc;

    // Stall only a final bit that would overwrite an unaccepted word.
    assign bus.in_ready = !((r_state == ST_RX) && (r_pos == PW'(L)) && r_valid && !bus.out_ready);
    assign w_acc        = bus.in_valid && bus.in_ready;

    always_comb begin
        w_pos   = bus.in_sof ? PW'(1) : r_pos;
        w_take  = bus.in_sof || (r_state == ST_RX);
        w_bad   = bus.in_sof ? (r_state == ST_RX) : (r_state == ST_IDLE);
        w_final = w_take && (w_pos == PW'(L));
        w_load  = w_acc && w_final;
        w_buf   = bus.in_sof ? '0 : r_buf;
        for (int p = 1; p <= N; p++)
            if (!is_pow2(p) && (w_pos == PW'(p)))
                w_buf[data_index(p)] = bus.in_bit;
        // The ext bit position (N+1) contributes nothing to the syndrome.
        w_syn = (bus.in_sof ? '0 : r_syn)
              ^ ((bus.in_bit && (w_pos <= PW'(N))) ? w_pos[R-1:0] : '0);
        w_par = (bus.in_sof ? 1'b0 : r_par) ^ bus.in_bit;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_acc && w_take)
            w_state_nxt = w_final ? ST_IDLE : ST_RX;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    hamming_secded_serial_decoder_correct #(.R(R), .EXT(EXT)) u_correct (
        .i_data (w_buf),
        .i_syn  (w_syn),
        .i_par  (w_par),
        .o_data (w_data),
        .o_corr (w_corr),
        .o_unc  (w_unc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos <= PW'(1);
            r_buf <= '0;
            r_syn <= '0;
            r_par <= 1'b0;
        end else if (w_acc && w_take) begin
            r_pos <= w_final ? PW'(1) : w_pos + PW'(1);
            r_buf <= w_final ? '0 : w_buf;
            r_syn <= w_final ? '0 : w_syn;
            r_par <= w_final ? 1'b0 : w_par;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data     <= '0;
            r_syn_out  <= '0;
            r_corr     <= 1'b0;
            r_unc      <= 1'b0;
            r_valid    <= 1'b0;
            r_sync_err <= 1'b0;
            r_cnt_corr <= '0;
            r_cnt_unc  <= '0;
        end else begin
            r_sync_err <= w_acc && w_bad;
            if (w_load) begin
                r_data    <= w_data;
                r_syn_out <= w_syn;
                r_corr    <= w_corr;
                r_unc     <= w_unc;
                r_valid   <= 1'b1;
                if (w_corr && (r_cnt_corr != '1)) r_cnt_corr <= r_cnt_corr + 1'b1;
                if (w_unc  && (r_cnt_unc  != '1)) r_cnt_unc  <= r_cnt_unc  + 1'b1;
            end else if (bus.out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.out_data      = r_data;
    assign bus.out_syndrome  = r_syn_out;
    assign bus.out_corrected = r_corr;
    assign bus.out_uncorr    = r_unc;
    assign bus.out_valid     = r_valid;
    assign bus.sync_err      = r_sync_err;
    assign bus.cnt_corr      = r_cnt_corr;
    assign bus.cnt_uncorr    = r_cnt_unc;
endmodule

// File: tb/tb_hamming_secded_serial_decoder.sv
module tb_hamming_secded_serial_decoder;
    localparam int R = 4, EXT = 1, CNTW = 4, K = 11;
    localparam int SAT = (1 << CNTW) - 1;
    typedef logic [16:1] frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hamming_secded_serial_decoder_if #(.R(R), .CNTW(CNTW)) bus ();

    hamming_secded_serial_decoder #(.R(R), .EXT(EXT), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errs = 0, checks = 0;
    int exp_cc = 0, exp_cu = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit pw2(int p);
        return (p & (p - 1)) == 0;
    endfunction

    // Systematic encoder: data in non-power positions, parity at 2**j, overall parity at 16.
    function automatic frame_t encode(logic [10:0] d);
        frame_t f;
        int k;
        f = '0;
        k = 0;
        for (int p = 1; p <= 15; p++)
            if (!pw2(p)) begin f[p] = d[k]; k++; end
        for (int j = 0; j < 4; j++)
            for (int p = 1; p <= 15; p++)
                if (!pw2(p) && ((p >> j) & 1) == 1) f[1 << j] = f[1 << j] ^ f[p];
        f[16] = ^f[15:1];
        return f;
    endfunction

    function automatic logic [10:0] extract(frame_t f);
        logic [10:0] d;
        int k;
        d = '0;
        k = 0;
        for (int p = 1; p <= 15; p++)
            if (!pw2(p)) begin d[k] = f[p]; k++; end
        return d;
    endfunction

    task automatic send(input logic b, input logic sof);
        int n;
        n = 0;
        bus.in_bit = b;
        bus.in_sof = sof;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errs++;
            $error("FAIL send_timeout: in_ready stuck at %0b expected 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
    endtask

    task automatic send_bits(input frame_t f, input int from, input int to);
        for (int p = from; p <= to; p++) send(f[p], p == 1);
    endtask

    task automatic expect_out(input string tag, input logic [10:0] d, input logic [3:0] s,
                              input logic c, input logic u);
        if (c && exp_cc < SAT) exp_cc++;
        if (u && exp_cu < SAT) exp_cu++;
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_data"}, bus.out_data, d);
        chk({tag, "_syn"}, bus.out_syndrome, s);
        chk({tag, "_corr"}, bus.out_corrected, c);
        chk({tag, "_unc"}, bus.out_uncorr, u);
        chk({tag, "_cntc"}, bus.cnt_corr, exp_cc);
        chk({tag, "_cntu"}, bus.cnt_uncorr, exp_cu);
    endtask

    frame_t f, fb;
    logic [10:0] d;
    int nerr, p1, p2;
    logic [3:0] es;

    initial begin
        bus.in_bit = 0; bus.in_sof = 0; bus.in_valid = 0; bus.out_ready = 1;
        repeat (2) @(posedge clk); #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_data", bus.out_data, 0);
        chk("rst_sync", bus.sync_err, 0);
        chk("rst_cnt", {bus.cnt_corr, bus.cnt_uncorr}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All-zero frame; result appears on the final-bit edge.
        f = '0;
        send_bits(f, 1, 15);
        chk("zero_pre_valid", bus.out_valid, 0);
        send_bits(f, 16, 16);
        expect_out("zero", 11'h000, 4'd0, 0, 0);

        f = '1; f[5] = ~f[5];
        send_bits(f, 1, 16);
        expect_out("ones_p5", 11'h7FF, 4'd5, 1, 0);

        f = '1; f[3] = ~f[3]; f[6] = ~f[6];
        send_bits(f, 1, 16);
        expect_out("ones_p3p6", 11'h7FA, 4'd5, 0, 1);

        f = '0; f[16] = 1'b1;
        send_bits(f, 1, 16);
        expect_out("ext_flip", 11'h000, 4'd0, 1, 0);
        @(posedge clk); #1;

        // Backpressure across two frames.
        bus.out_ready = 1'b0;
        f = encode(11'h123);
        send_bits(f, 1, 16);
        expect_out("bp_a", 11'h123, 4'd0, 0, 0);
        fb = encode(11'h456);
        send_bits(fb, 1, 15);
        chk("bp_inready", bus.in_ready, 0);
        bus.in_bit = fb[16]; bus.in_valid = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("bp_inready_held", bus.in_ready, 0);
        chk("bp_hold_valid", bus.out_valid, 1);
        chk("bp_hold_data", bus.out_data, 11'h123);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        expect_out("bp_b", 11'h456, 4'd0, 0, 0);
        @(posedge clk); #1;
        chk("bp_retired", bus.out_valid, 0);

        // in_sof at position 7 aborts the partial frame.
        f = encode(11'h5A5);
        send_bits(f, 1, 6);
        chk("sync_none", bus.sync_err, 0);
        send(f[1], 1'b1);
        chk("sync_sof_pulse", bus.sync_err, 1);
        send_bits(f, 2, 2);
        chk("sync_sof_end", bus.sync_err, 0);
        send_bits(f, 3, 16);
        expect_out("sync_frame", 11'h5A5, 4'd0, 0, 0);
        send(1'b1, 1'b0);
        chk("sync_nosof_pulse", bus.sync_err, 1);
        chk("sync_nosof_novalid", bus.out_valid, 0);
        @(posedge clk); #1;
        chk("sync_nosof_end", bus.sync_err, 0);

        // Reset while a word is held and a frame is in progress.
        bus.out_ready = 1'b0;
        f = encode(11'h3C3); f[9] = ~f[9];
        send_bits(f, 1, 16);
        expect_out("prerst", 11'h3C3, 4'd9, 1, 0);
        send_bits(encode(11'h0F0), 1, 5);
        rst_n = 1'b0; #1;
        exp_cc = 0; exp_cu = 0;
        chk("mrst_valid", bus.out_valid, 0);
        chk("mrst_ready", bus.in_ready, 1);
        chk("mrst_data", bus.out_data, 0);
        chk("mrst_cnt", {bus.cnt_corr, bus.cnt_uncorr}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; bus.out_ready = 1'b1;
        send(1'b0, 1'b0);
        chk("mrst_idle", bus.sync_err, 1);
        f = encode(11'h0F0);
        send_bits(f, 1, 16);
        expect_out("mrst_frame", 11'h0F0, 4'd0, 0, 0);

        // Random frames with 0/1/2 errors; counters saturate at 15.
        for (int t = 0; t < 60; t++) begin
            d = 11'($urandom);
            nerr = $urandom_range(0, 2);
            p1 = $urandom_range(1, 16);
            do p2 = $urandom_range(1, 16); while (p2 == p1);
            f = encode(d);
            if (nerr >= 1) f[p1] = ~f[p1];
            if (nerr == 2) f[p2] = ~f[p2];
            send_bits(f, 1, 16);
            if (nerr == 0) expect_out("rnd0", d, 4'd0, 0, 0);
            else if (nerr == 1) expect_out("rnd1", d, (p1 <= 15) ? 4'(p1) : 4'd0, 1, 0);
            else begin
                es = ((p1 <= 15) ? 4'(p1) : 4'd0) ^ ((p2 <= 15) ? 4'(p2) : 4'd0);
                expect_out("rnd2", extract(f), es, 0, 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
